// File: rtl/mem_stage.sv
// mem_stage: MIPS memory stage (EX/MEM register, data RAM, branch resolve, MEM/WB register).
// Latency: non-memory ops reach MEM/WB 2 edges after entry; a load/store holds the stage MEM_LATENCY cycles.
// Backpressure: stall holds EX/MEM and tells upstream to hold while a RAM access is in flight.
// Ports: clk/rst_n (sync active-low); ex_valid + EX payload + decode controls + flush in;
//        stall, pc_src, branch_target, misaligned, wb_valid/wb_reg_write/wb_reg_addr/wb_data out.
module mem_stage #(
    parameter int MEM_DEPTH   = 512,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] alu_out,
    input  logic [31:0] write_data,
    input  logic [4:0]  write_reg_addr,
    input  logic        zero,
    input  logic [31:0] pc_branch,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic        mem_to_reg,
    input  logic        branch_eq,
    input  logic        branch_ne,
    input  logic        flush,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        misaligned,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_reg_addr,
    output logic [31:0] wb_data
);

    localparam int ADDR_W = $clog2(MEM_DEPTH);
    localparam int CNT_W  = $clog2(MEM_LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);
    localparam bit MULTI_CYCLE = (MEM_LATENCY > 1);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    // EX/MEM register
    logic        em_valid;
    logic [31:0] em_alu_out;
    logic [31:0] em_write_data;
    logic [4:0]  em_write_reg_addr;
    logic        em_zero;
    logic [31:0] em_pc_branch;
    logic        em_mem_read;
    logic        em_mem_write;
    logic        em_reg_write;
    logic        em_mem_to_reg;
    logic        em_branch_eq;
    logic        em_branch_ne;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;

    logic [31:0]       ram [MEM_DEPTH];
    logic [ADDR_W-1:0] word_addr;
    logic              mem_op;
    logic              aligned;
    logic              do_store;
    logic [31:0]       load_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            em_valid          <= 1'b0;
            em_alu_out        <= '0;
            em_write_data     <= '0;
            em_write_reg_addr <= '0;
            em_zero           <= 1'b0;
            em_pc_branch      <= '0;
            em_mem_read       <= 1'b0;
            em_mem_write      <= 1'b0;
            em_reg_write      <= 1'b0;
            em_mem_to_reg     <= 1'b0;
            em_branch_eq      <= 1'b0;
            em_branch_ne      <= 1'b0;
        end else if (!stall) begin
            em_valid          <= ex_valid & ~flush;
            em_alu_out        <= alu_out;
            em_write_data     <= write_data;
            em_write_reg_addr <= write_reg_addr;
            em_zero           <= zero;
            em_pc_branch      <= pc_branch;
            em_mem_read       <= mem_read;
            em_mem_write      <= mem_write;
            em_reg_write      <= reg_write;
            em_mem_to_reg     <= mem_to_reg;
            em_branch_eq      <= branch_eq;
            em_branch_ne      <= branch_ne;
        end
    end

    assign mem_op    = em_valid & (em_mem_read | em_mem_write);
    assign aligned   = (em_alu_out[1:0] == 2'b00);
    // Upper address bits are dropped, so addresses wrap modulo MEM_DEPTH words.
    assign word_addr = em_alu_out[ADDR_W+1:2];

    // Access FSM: IDLE covers the first cycle of an access, ACCESS counts the rest.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_op && MULTI_CYCLE) begin
                    state_nxt = S_ACCESS;
                    cnt_nxt   = CNT_W'(1);
                    stall     = 1'b1;
                end
            end
            S_ACCESS: begin
                if (cnt < CNT_LAST) begin
                    cnt_nxt = cnt + 1'b1;
                    stall   = mem_op;
                end else begin
                    // cnt == LAST: this is the completion cycle
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Write when read and write are both set too: such an entry is a store.
    // A reset edge drops an in-flight store.
    assign do_store  = mem_op & em_mem_write & aligned & ~stall;
    // Asynchronous read: a same-edge store lands after this sample, so the old word is returned.
    assign load_data = aligned ? ram[word_addr] : 32'h0;

    always_ff @(posedge clk) begin
        if (rst_n && do_store) begin
            ram[word_addr] <= em_write_data;
        end
    end

    // MEM/WB register, updated on every non-stalled edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_reg_addr  <= '0;
            wb_data      <= '0;
        end else if (!stall) begin
            wb_valid     <= em_valid;
            wb_reg_write <= em_valid & em_reg_write;
            wb_reg_addr  <= em_write_reg_addr;
            wb_data      <= em_mem_to_reg ? load_data : em_alu_out;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misaligned <= 1'b0;
        end else if (mem_op && !aligned) begin
            misaligned <= 1'b1;
        end
    end

    assign pc_src        = em_valid & ((em_branch_eq & em_zero) | (em_branch_ne & ~em_zero));
    assign branch_target = em_pc_branch;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with four instances (MEM_LATENCY = 1..4) on shared inputs.
// Each scenario resets all instances first and checks only the instance whose latency it targets.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mem_stage;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] alu_out;
    logic [31:0] write_data;
    logic [4:0]  write_reg_addr;
    logic        zero;
    logic [31:0] pc_branch;
    logic        mem_read, mem_write, reg_write, mem_to_reg, branch_eq, branch_ne;
    logic        flush;

    logic        stall_a        [4];
    logic        pc_src_a       [4];
    logic [31:0] branch_target_a[4];
    logic        misaligned_a   [4];
    logic        wb_valid_a     [4];
    logic        wb_reg_write_a [4];
    logic [4:0]  wb_reg_addr_a  [4];
    logic [31:0] wb_data_a      [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mem_stage #(.MEM_DEPTH(DEPTH), .MEM_LATENCY(g + 1)) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .ex_valid       (ex_valid),
            .alu_out        (alu_out),
            .write_data     (write_data),
            .write_reg_addr (write_reg_addr),
            .zero           (zero),
            .pc_branch      (pc_branch),
            .mem_read       (mem_read),
            .mem_write      (mem_write),
            .reg_write      (reg_write),
            .mem_to_reg     (mem_to_reg),
            .branch_eq      (branch_eq),
            .branch_ne      (branch_ne),
            .flush          (flush),
            .stall          (stall_a[g]),
            .pc_src         (pc_src_a[g]),
            .branch_target  (branch_target_a[g]),
            .misaligned     (misaligned_a[g]),
            .wb_valid       (wb_valid_a[g]),
            .wb_reg_write   (wb_reg_write_a[g]),
            .wb_reg_addr    (wb_reg_addr_a[g]),
            .wb_data        (wb_data_a[g])
        );
    end

    task automatic set_in(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                          input logic [4:0] rd, input logic z, input logic [31:0] pcb,
                          input logic mr, input logic mw, input logic rw, input logic m2r,
                          input logic beq, input logic bne, input logic fl);
        ex_valid = v; alu_out = alu; write_data = wd; write_reg_addr = rd; zero = z;
        pc_branch = pcb; mem_read = mr; mem_write = mw; reg_write = rw; mem_to_reg = m2r;
        branch_eq = beq; branch_ne = bne; flush = fl;
    endtask

    task automatic clear_in();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Called on a falling edge; returns on the falling edge of the cycle after reset.
    task automatic do_reset();
        clear_in();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Presents a load (mr=1) or store (mw=1) and holds it for lat cycles; returns in the
    // completion cycle with the inputs cleared.
    task automatic run_mem(input int lat, input logic [31:0] addr, input logic [31:0] wd,
                           input logic mr, input logic mw, input logic [4:0] rd);
        set_in(1, addr, wd, rd, 0, 0, mr, mw, mr, mr, 0, 0, 0);
        repeat (lat) @(negedge clk);
        clear_in();
    endtask

    task automatic test_reset();
        // Busy inputs during reset must not leak through.
        set_in(1, 32'h7, 32'h1234, 5'd9, 1, 32'h99, 0, 1, 1, 0, 1, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (stall_a[1] !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_a[1]); end
        checks++; if (pc_src_a[1] !== 1'b0) begin errors++; $display("FAIL reset_pc_src: got %b want 0", pc_src_a[1]); end
        checks++; if (branch_target_a[1] !== 32'h0) begin errors++; $display("FAIL reset_branch_target: got %h want 0", branch_target_a[1]); end
        checks++; if (misaligned_a[1] !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %b want 0", misaligned_a[1]); end
        checks++; if (wb_valid_a[1] !== 1'b0 || wb_reg_write_a[1] !== 1'b0) begin errors++; $display("FAIL reset_wb_flags: got %b%b want 00", wb_valid_a[1], wb_reg_write_a[1]); end
        checks++; if (wb_reg_addr_a[1] !== 5'd0 || wb_data_a[1] !== 32'h0) begin errors++; $display("FAIL reset_wb_fields: got %0d/%h want 0/0", wb_reg_addr_a[1], wb_data_a[1]); end
        rst_n = 1'b1;
        clear_in();
        @(negedge clk);
        // add r3 = 0x5
        set_in(1, 32'h5, 0, 5'd3, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        clear_in();
        checks++; if (stall_a[1] !== 1'b0) begin errors++; $display("FAIL add_no_stall: got %b want 0", stall_a[1]); end
        checks++; if (wb_valid_a[1] !== 1'b0) begin errors++; $display("FAIL add_wb_early: got %b want 0", wb_valid_a[1]); end
        @(negedge clk);
        checks++; if (wb_valid_a[1] !== 1'b1 || wb_reg_write_a[1] !== 1'b1) begin errors++; $display("FAIL add_wb_flags: got %b%b want 11", wb_valid_a[1], wb_reg_write_a[1]); end
        checks++; if (wb_reg_addr_a[1] !== 5'd3 || wb_data_a[1] !== 32'h5) begin errors++; $display("FAIL add_wb_result: got %0d/%h want 3/5", wb_reg_addr_a[1], wb_data_a[1]); end
    endtask

    task automatic test_store_load();
        do_reset();
        set_in(1, 32'h10, 32'hDEADBEEF, 5'd0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (stall_a[2] !== 1'b1) begin errors++; $display("FAIL st_stall_c1: got %b want 1", stall_a[2]); end
        @(negedge clk);
        checks++; if (stall_a[2] !== 1'b1) begin errors++; $display("FAIL st_stall_c2: got %b want 1", stall_a[2]); end
        @(negedge clk);
        checks++; if (stall_a[2] !== 1'b0) begin errors++; $display("FAIL st_stall_c3: got %b want 0", stall_a[2]); end
        // Load enters EX/MEM on the store's completion edge.
        set_in(1, 32'h10, 0, 5'd8, 0, 0, 1, 0, 1, 1, 0, 0, 0);
        @(negedge clk);
        checks++; if (wb_valid_a[2] !== 1'b1 || wb_reg_write_a[2] !== 1'b0) begin errors++; $display("FAIL st_wb: got %b%b want 10", wb_valid_a[2], wb_reg_write_a[2]); end
        checks++; if (stall_a[2] !== 1'b1) begin errors++; $display("FAIL ld_stall_c1: got %b want 1", stall_a[2]); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (stall_a[2] !== 1'b0) begin errors++; $display("FAIL ld_stall_c3: got %b want 0", stall_a[2]); end
        checks++; if (wb_reg_addr_a[2] !== 5'd0) begin errors++; $display("FAIL ld_wb_early: got %0d want 0", wb_reg_addr_a[2]); end
        clear_in();
        @(negedge clk);
        checks++; if (wb_data_a[2] !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_data: got %h want deadbeef", wb_data_a[2]); end
        checks++; if (wb_reg_addr_a[2] !== 5'd8 || wb_reg_write_a[2] !== 1'b1) begin errors++; $display("FAIL ld_dest: got %0d/%b want 8/1", wb_reg_addr_a[2], wb_reg_write_a[2]); end
    endtask

    task automatic test_wrap();
        do_reset();
        run_mem(2, 32'd256, 32'h1, 0, 1, 5'd0);   // 4*DEPTH wraps to word 0
        run_mem(2, 32'd0, 32'h0, 1, 0, 5'd2);
        @(negedge clk);
        checks++; if (wb_data_a[1] !== 32'h1 || wb_reg_addr_a[1] !== 5'd2) begin errors++; $display("FAIL wrap_load: got %h/%0d want 1/2", wb_data_a[1], wb_reg_addr_a[1]); end
    endtask

    task automatic test_misaligned();
        do_reset();
        run_mem(2, 32'h10, 32'hCAFE0000, 0, 1, 5'd0);
        @(negedge clk);
        checks++; if (misaligned_a[1] !== 1'b0) begin errors++; $display("FAIL mis_aligned_store: got %b want 0", misaligned_a[1]); end
        run_mem(2, 32'h13, 32'h12345678, 0, 1, 5'd0);
        run_mem(2, 32'h12, 32'h0, 1, 0, 5'd7);
        @(negedge clk);
        checks++; if (misaligned_a[1] !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b want 1", misaligned_a[1]); end
        checks++; if (wb_data_a[1] !== 32'h0 || wb_valid_a[1] !== 1'b1) begin errors++; $display("FAIL mis_load: got %h/%b want 0/1", wb_data_a[1], wb_valid_a[1]); end
        run_mem(2, 32'h10, 32'h0, 1, 0, 5'd7);
        @(negedge clk);
        checks++; if (wb_data_a[1] !== 32'hCAFE0000) begin errors++; $display("FAIL mis_word_kept: got %h want cafe0000", wb_data_a[1]); end
        checks++; if (misaligned_a[1] !== 1'b1) begin errors++; $display("FAIL mis_sticky: got %b want 1", misaligned_a[1]); end
    endtask

    task automatic test_branch();
        do_reset();
        set_in(1, 0, 0, 0, 1, 32'h40, 0, 0, 0, 0, 1, 0, 0);   // beq, zero=1
        @(negedge clk);
        clear_in();
        checks++; if (pc_src_a[1] !== 1'b1 || branch_target_a[1] !== 32'h40) begin errors++; $display("FAIL beq_taken: got %b/%h want 1/40", pc_src_a[1], branch_target_a[1]); end
        @(negedge clk);
        checks++; if (pc_src_a[1] !== 1'b0) begin errors++; $display("FAIL beq_one_cycle: got %b want 0", pc_src_a[1]); end
        set_in(1, 0, 0, 0, 1, 32'h80, 0, 0, 0, 0, 0, 1, 0);   // bne, zero=1
        @(negedge clk);
        checks++; if (pc_src_a[1] !== 1'b0 || branch_target_a[1] !== 32'h80) begin errors++; $display("FAIL bne_not_taken: got %b/%h want 0/80", pc_src_a[1], branch_target_a[1]); end
        set_in(1, 0, 0, 0, 0, 32'hC0, 0, 0, 0, 0, 0, 1, 0);   // bne, zero=0
        @(negedge clk);
        checks++; if (pc_src_a[1] !== 1'b1) begin errors++; $display("FAIL bne_taken: got %b want 1", pc_src_a[1]); end
        set_in(1, 32'h9, 0, 5'd4, 1, 32'h40, 0, 0, 1, 0, 1, 0, 1); // flushed add/beq
        @(negedge clk);
        clear_in();
        checks++; if (pc_src_a[1] !== 1'b0) begin errors++; $display("FAIL flush_pc_src: got %b want 0", pc_src_a[1]); end
        @(negedge clk);
        checks++; if (wb_valid_a[1] !== 1'b0 || wb_reg_write_a[1] !== 1'b0) begin errors++; $display("FAIL flush_wb: got %b%b want 00", wb_valid_a[1], wb_reg_write_a[1]); end
    endtask

    task automatic test_latency1();
        do_reset();
        set_in(1, 32'h8, 32'h77, 5'd0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (stall_a[0] !== 1'b0) begin errors++; $display("FAIL l1_store_stall: got %b want 0", stall_a[0]); end
        set_in(1, 32'h8, 0, 5'd6, 0, 0, 1, 0, 1, 1, 0, 0, 0);
        @(negedge clk);
        clear_in();
        checks++; if (stall_a[0] !== 1'b0) begin errors++; $display("FAIL l1_load_stall: got %b want 0", stall_a[0]); end
        @(negedge clk);
        checks++; if (wb_data_a[0] !== 32'h77 || wb_reg_addr_a[0] !== 5'd6) begin errors++; $display("FAIL l1_load: got %h/%0d want 77/6", wb_data_a[0], wb_reg_addr_a[0]); end
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        run_mem(4, 32'h20, 32'h11, 0, 1, 5'd0);
        set_in(1, 32'h20, 32'h55, 5'd0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        checks++; if (stall_a[3] !== 1'b1) begin errors++; $display("FAIL mid_stall_before: got %b want 1", stall_a[3]); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_in();
        checks++; if (stall_a[3] !== 1'b0) begin errors++; $display("FAIL mid_stall_after: got %b want 0", stall_a[3]); end
        run_mem(4, 32'h20, 32'h0, 1, 0, 5'd5);
        @(negedge clk);
        checks++; if (wb_data_a[3] !== 32'h11) begin errors++; $display("FAIL mid_store_dropped: got %h want 11", wb_data_a[3]); end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_in();
        @(negedge clk);
        test_reset();
        test_store_load();
        test_wrap();
        test_misaligned();
        test_branch();
        test_latency1();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
